// File: rtl/pc_dispatch_scheduler.sv
// pc_dispatch_scheduler: per-queue task counters feeding round-robin PC grants to idle cores
module pc_dispatch_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int NUM_QUEUES = 16,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wen,
    input  logic [3:0]             cfg_queue,
    input  logic [15:0]            cfg_pc,
    input  logic                   seed_wen,
    input  logic [3:0]             seed_queue,
    input  logic [NUM_CORES-1:0]   core_req,
    input  logic [NUM_CORES-1:0]   core_qwen,
    input  logic [4*NUM_CORES-1:0] core_qnum,
    output logic [NUM_CORES-1:0]   core_set_pc,
    output logic [16*NUM_CORES-1:0] core_new_pc,
    output logic                   idle,
    output logic                   overflow
);
    localparam int PW = $clog2(NUM_CORES);
    localparam logic [CNT_W+3:0] MAX = {4'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] count     [NUM_QUEUES];
    logic [CNT_W-1:0] count_nxt [NUM_QUEUES];
    logic [15:0]      base_pc   [NUM_QUEUES];
    logic [PW-1:0]    rr_ptr, gnt, idx;
    logic [3:0]       sel_q;
    logic [NUM_CORES-1:0] eligible;
    logic [CNT_W+3:0] sum;
    logic any_work, found, grant, sat;

    always_comb begin
        any_work = 1'b0;
        sel_q = '0;
        for (int q = NUM_QUEUES - 1; q >= 0; q--)
            if (count[q] != '0) begin
                any_work = 1'b1;
                sel_q = 4'(q);
            end
    end

    // A core still seeing its set_pc pulse is masked so it cannot be granted twice
    assign eligible = core_req & ~core_set_pc;

    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
            if (eligible[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end

    assign grant = any_work & found;

    // Pushes and the pop share one adder so a same-edge push/pop nets out
    always_comb begin
        sat = 1'b0;
        sum = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            sum = {4'b0, count[q]} + (CNT_W+4)'(seed_wen && seed_queue == 4'(q));
            for (int i = 0; i < NUM_CORES; i++)
                sum = sum + (CNT_W+4)'(core_qwen[i] && core_qnum[4*i +: 4] == 4'(q));
            sum = sum - (CNT_W+4)'(grant && sel_q == 4'(q));
            count_nxt[q] = (sum > MAX) ? '1 : sum[CNT_W-1:0];
            sat = sat | (sum > MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                count[q]   <= '0;
                base_pc[q] <= '0;
            end
            rr_ptr      <= '0;
            overflow    <= 1'b0;
            core_set_pc <= '0;
            core_new_pc <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++)
                count[q] <= count_nxt[q];
            if (cfg_wen)
                base_pc[cfg_queue] <= cfg_pc;
            if (sat)
                overflow <= 1'b1;
            core_set_pc <= '0;
            if (grant) begin
                core_set_pc[gnt] <= 1'b1;
                core_new_pc[16*gnt +: 16] <= base_pc[sel_q];
                rr_ptr <= (int'(gnt) == NUM_CORES - 1) ? '0 : gnt + 1'b1;
            end
        end
    end

    assign idle = ~any_work & (&core_req) & ~(|core_set_pc);
endmodule

// File: tb/tb_pc_dispatch_scheduler.sv
// tb_pc_dispatch_scheduler: scoreboard of expected grants plus per-scenario timing checks
module tb_pc_dispatch_scheduler;
    localparam int N = 4;
    typedef struct packed {
        logic [N-1:0] mask;
        logic [15:0]  pc;
    } exp_t;

    logic clk = 0, rst_n = 0, cfg_wen = 0, seed_wen = 0;
    logic [3:0] cfg_queue = 0, seed_queue = 0;
    logic [15:0] cfg_pc = 0;
    logic [N-1:0] core_req = 0, req2 = 0, core_qwen = 0;
    logic [4*N-1:0] core_qnum = 0;
    logic [N-1:0] set_pc, set_pc2;
    logic [16*N-1:0] new_pc, new_pc2;
    logic idle, overflow, idle2, ovf2;

    exp_t sb[$];
    exp_t e;
    logic [15:0] got_pc;
    int tests = 0, fails = 0;

    pc_dispatch_scheduler #(.NUM_CORES(N), .NUM_QUEUES(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wen(cfg_wen), .cfg_queue(cfg_queue), .cfg_pc(cfg_pc),
        .seed_wen(seed_wen), .seed_queue(seed_queue), .core_req(core_req), .core_qwen(core_qwen),
        .core_qnum(core_qnum), .core_set_pc(set_pc), .core_new_pc(new_pc), .idle(idle),
        .overflow(overflow));

    pc_dispatch_scheduler #(.NUM_CORES(N), .NUM_QUEUES(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_wen(cfg_wen), .cfg_queue(cfg_queue), .cfg_pc(cfg_pc),
        .seed_wen(seed_wen), .seed_queue(seed_queue), .core_req(req2), .core_qwen(core_qwen),
        .core_qnum(core_qnum), .core_set_pc(set_pc2), .core_new_pc(new_pc2), .idle(idle2),
        .overflow(ovf2));

    always #5 clk = ~clk;

    // Every pulse on the main DUT must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && set_pc != '0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL grant_unexpected: set_pc=%b new_pc=%h, required no grant", set_pc, new_pc);
            end else begin
                e = sb.pop_front();
                got_pc = 'x;
                for (int i = 0; i < N; i++)
                    if (set_pc[i]) got_pc = new_pc[16*i +: 16];
                if (set_pc !== e.mask || got_pc !== e.pc) begin
                    fails++;
                    $display("FAIL grant: set_pc=%b pc=%h, required set_pc=%b pc=%h", set_pc, got_pc, e.mask, e.pc);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] q, input logic [15:0] pc);
        cfg_wen = 1; cfg_queue = q; cfg_pc = pc;
        cyc();
        cfg_wen = 0;
    endtask

    task automatic seed(input logic [3:0] q);
        seed_wen = 1; seed_queue = q;
        cyc();
        seed_wen = 0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (set_pc !== '0 || new_pc !== '0 || overflow !== 1'b0) begin fails++; $display("FAIL reset_init: set_pc=%b new_pc=%h ovf=%b, required 0", set_pc, new_pc, overflow); end
        cyc(); cyc();
        rst_n = 1;
        cyc();
        cfg(3, 16'h0033);
        repeat (5) seed(3);
        core_req = 4'b0010;
        cyc();
        tests++; if (set_pc !== 4'b0010) begin fails++; $display("FAIL reset_pre_pulse: set_pc=%b, required 0010", set_pc); end
        #1;
        rst_n = 0;
        #1;
        tests++; if (set_pc !== '0 || new_pc !== '0 || overflow !== 1'b0) begin fails++; $display("FAIL reset_async: set_pc=%b new_pc=%h ovf=%b, required 0", set_pc, new_pc, overflow); end
        core_req = 0;
        cyc();
        rst_n = 1;
        core_req = 4'hF;
        cyc(); cyc();
        tests++; if (idle !== 1'b1 || set_pc !== '0) begin fails++; $display("FAIL reset_count_cleared: idle=%b set_pc=%b, required idle=1 set_pc=0", idle, set_pc); end
        core_req = 0;
        cyc();
    endtask

    task automatic test_basic();
        cfg(3, 16'h0040);
        seed(3); seed(3);
        core_req = 4'b0001;
        sb.push_back('{4'b0001, 16'h0040});
        cyc();
        tests++; if (set_pc !== 4'b0001 || new_pc[15:0] !== 16'h0040) begin fails++; $display("FAIL basic_grant: set_pc=%b pc=%h, required 0001 0040", set_pc, new_pc[15:0]); end
        cyc();
        tests++; if (set_pc !== 4'b0000) begin fails++; $display("FAIL basic_no_double: set_pc=%b, required 0000", set_pc); end
        core_req = 4'b1000;
        sb.push_back('{4'b1000, 16'h0040});
        cyc();
        tests++; if (set_pc !== 4'b1000) begin fails++; $display("FAIL basic_drain: set_pc=%b, required 1000", set_pc); end
        core_req = 4'hF;
        cyc(); cyc();
        tests++; if (idle !== 1'b1 || set_pc !== '0) begin fails++; $display("FAIL basic_empty: idle=%b set_pc=%b, required idle=1 set_pc=0", idle, set_pc); end
        core_req = 0;
        cyc();
    endtask

    task automatic test_round_robin();
        cfg(0, 16'h0100);
        repeat (4) seed(0);
        core_req = 4'hF;
        for (int i = 0; i < N; i++) sb.push_back('{4'(1 << i), 16'h0100});
        for (int i = 0; i < N; i++) begin
            cyc();
            tests++; if (set_pc !== 4'(1 << i) || idle !== 1'b0) begin fails++; $display("FAIL rr_order_%0d: set_pc=%b idle=%b, required %b idle=0", i, set_pc, idle, 4'(1 << i)); end
        end
        cyc();
        tests++; if (idle !== 1'b1 || set_pc !== '0) begin fails++; $display("FAIL rr_idle: idle=%b set_pc=%b, required idle=1 set_pc=0", idle, set_pc); end
        core_req = 0;
        cyc();
    endtask

    task automatic test_queue_priority();
        cfg(5, 16'h0500);
        cfg(2, 16'h0200);
        seed(5); seed(2);
        core_req = 4'b0010;
        sb.push_back('{4'b0010, 16'h0200});
        sb.push_back('{4'b0010, 16'h0500});
        cyc();
        tests++; if (set_pc !== 4'b0010 || new_pc[31:16] !== 16'h0200) begin fails++; $display("FAIL prio_first: set_pc=%b pc=%h, required 0010 0200", set_pc, new_pc[31:16]); end
        cyc();
        tests++; if (set_pc !== 4'b0000) begin fails++; $display("FAIL prio_mask: set_pc=%b, required 0000", set_pc); end
        cyc();
        tests++; if (set_pc !== 4'b0010 || new_pc[31:16] !== 16'h0500) begin fails++; $display("FAIL prio_second: set_pc=%b pc=%h, required 0010 0500", set_pc, new_pc[31:16]); end
        core_req = 0;
        cyc();
    endtask

    task automatic test_simultaneous();
        cfg(1, 16'h0111);
        seed(1);
        core_req = 4'b0001;
        core_qwen = 4'b0110;
        core_qnum = 16'h0110;
        cfg_wen = 1; cfg_queue = 1; cfg_pc = 16'h0777;
        sb.push_back('{4'b0001, 16'h0111});
        cyc();
        core_qwen = 0; core_qnum = 0; cfg_wen = 0;
        tests++; if (set_pc !== 4'b0001 || new_pc[15:0] !== 16'h0111) begin fails++; $display("FAIL simul_old_pc: set_pc=%b pc=%h, required 0001 0111", set_pc, new_pc[15:0]); end
        core_req = 4'b0110;
        sb.push_back('{4'b0010, 16'h0777});
        sb.push_back('{4'b0100, 16'h0777});
        cyc();
        tests++; if (set_pc !== 4'b0010 || new_pc[31:16] !== 16'h0777) begin fails++; $display("FAIL simul_new_pc: set_pc=%b pc=%h, required 0010 0777", set_pc, new_pc[31:16]); end
        cyc();
        tests++; if (set_pc !== 4'b0100) begin fails++; $display("FAIL simul_second: set_pc=%b, required 0100", set_pc); end
        cyc();
        tests++; if (set_pc !== 4'b0000) begin fails++; $display("FAIL simul_count2: set_pc=%b, required 0000", set_pc); end
        core_req = 0;
        cyc();
    endtask

    task automatic test_saturation();
        int n;
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        cfg(4, 16'h0444);
        repeat (3) seed(4);
        tests++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL sat_pre: ovf=%b, required 0", ovf2); end
        seed_wen = 1; seed_queue = 4;
        core_qwen = 4'b0001; core_qnum = 16'h0004;
        cyc();
        seed_wen = 0; core_qwen = 0; core_qnum = 0;
        tests++; if (ovf2 !== 1'b1) begin fails++; $display("FAIL sat_flag: ovf=%b, required 1", ovf2); end
        n = 0;
        req2 = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (set_pc2[0]) begin
                n++;
                tests++; if (new_pc2[15:0] !== 16'h0444) begin fails++; $display("FAIL sat_pc: pc=%h, required 0444", new_pc2[15:0]); end
            end
        end
        req2 = 0;
        tests++; if (n !== 3) begin fails++; $display("FAIL sat_count: grants=%0d, required 3", n); end
        tests++; if (ovf2 !== 1'b1) begin fails++; $display("FAIL sat_sticky: ovf=%b, required 1", ovf2); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL wide_no_ovf: ovf=%b, required 0", overflow); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_queue_priority();
        test_simultaneous();
        test_saturation();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drained: %0d grants outstanding, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
